// File: rtl/logicsystem_sweeper.sv
// On-chip self-test sequencer for the 4-input logicsystem block: sweeps all 16
// input vectors, captures out per vector, checks out_n complementarity and grades the table.
module logicsystem_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        out,
  input  logic        out_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic        compl_err,
  output logic [3:0]  err_index,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic        cerr_q, cerr_d;
  logic [3:0]  eidx_q, eidx_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state and result-register computation for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    cerr_d  = cerr_q;
    eidx_d  = eidx_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          tt_d    = 16'd0;
          cerr_d  = 1'b0;
          eidx_d  = 4'd0;
          pass_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 8'd0;
          state_d = SAMPLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        tt_d[idx_q] = out;
        // Only the first complementarity violation is recorded.
        if ((out_n == out) && !cerr_q) begin
          cerr_d = 1'b1;
          eidx_d = idx_q;
        end else begin
          cerr_d = cerr_q;
        end
        if (idx_q == 4'd15) begin
          idx_d   = 4'd0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        pass_d  = (tt_q == expected) && !cerr_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      tt_q    <= 16'd0;
      cerr_q  <= 1'b0;
      eidx_q  <= 4'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      cerr_q  <= cerr_d;
      eidx_q  <= eidx_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a           = idx_q[0];
  assign b           = idx_q[1];
  assign c           = idx_q[2];
  assign d           = idx_q[3];
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign compl_err   = cerr_q;
  assign err_index   = eidx_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_logicsystem_sweeper.sv
// Scoreboard bench for logicsystem_sweeper: a behavioural logicsystem model with
// injectable out_n faults, expected results queued at stimulus time, checked at done.
module tb_logicsystem_sweeper;
  localparam int SC       = 2;
  localparam int BUSY_LEN = 16 * (SC + 1);

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] expected;
  logic        a, b, c, d, out, out_n, busy, done, compl_err, pass;
  logic [15:0] truth_table;
  logic [3:0]  err_index;

  logic [15:0] fn_r, flt_r;
  logic [3:0]  vec;

  typedef struct packed {
    logic [15:0] tt;
    logic        cerr;
    logic [3:0]  eidx;
    logic        pass;
  } res_t;

  res_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logicsystem_sweeper #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .a(a), .b(b), .c(c), .d(d), .out(out), .out_n(out_n),
    .busy(busy), .done(done), .truth_table(truth_table),
    .compl_err(compl_err), .err_index(err_index), .pass(pass)
  );

  always #5 clk = ~clk;

  // Logic block under test: arbitrary truth table, out_n optionally stuck equal to out.
  assign vec   = {d, c, b, a};
  assign out   = fn_r[vec];
  assign out_n = flt_r[vec] ? out : ~out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] fn, input logic [15:0] flt, input logic [15:0] ex);
    res_t r;
    r.tt   = fn;
    r.cerr = (flt != 16'd0);
    r.eidx = 4'd0;
    for (int i = 15; i >= 0; i--) if (flt[i]) r.eidx = 4'(i);
    r.pass = (fn == ex) && (flt == 16'd0);
    return r;
  endfunction

  // Monitor: vector sequencing while busy, result check on done, pass check one cycle later.
  int   busy_cnt  = 0;
  bit   pend_pass = 1'b0;
  logic exp_pass;
  res_t mr;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      pend_pass = 1'b0;
    end else begin
      if (pend_pass) begin
        check("pass", 32'(pass), 32'(exp_pass));
        check("done_width", 32'(done), 32'd0);
        pend_pass = 1'b0;
      end
      if (busy) begin
        check("vector", 32'(vec), 32'(busy_cnt / (SC + 1)));
        busy_cnt++;
      end else begin
        check("idle_vector", 32'(vec), 32'd0);
      end
      if (done) begin
        check("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done, required no sweep pending");
        end else begin
          mr = sb_q.pop_front();
          check("truth_table", 32'(truth_table), 32'(mr.tt));
          check("compl_err", 32'(compl_err), 32'(mr.cerr));
          check("err_index", 32'(err_index), 32'(mr.eidx));
          exp_pass  = mr.pass;
          pend_pass = 1'b1;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * BUSY_LEN; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: got no done, required done within %0d cycles", 4 * BUSY_LEN);
    end
  endtask

  // One sweep; expected is scrambled while busy since only the DONE-cycle value matters.
  task automatic sweep(input logic [15:0] fn, input logic [15:0] flt, input logic [15:0] ex, input bit noise);
    fn_r  = fn;
    flt_r = flt;
    sb_q.push_back(model(fn, flt, ex));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    expected = 16'($urandom);
    for (int i = 0; i < BUSY_LEN - 8; i++) begin
      @(posedge clk); #1 start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start    = 1'b0;
    expected = ex;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] fn, flt, ex;
    rst      = 1'b1;
    start    = 1'b0;
    expected = 16'd0;
    fn_r     = 16'hF888;
    flt_r    = 16'd0;
    #1;
    check("reset_state", 32'({a, b, c, d, busy, done, compl_err, pass, err_index, truth_table}), 32'd0);
    #21 rst = 1'b0;
    repeat (2) @(negedge clk);

    sweep(16'hF888, 16'd0, 16'hF888, 1'b0);
    sweep(16'hF888, 16'd0, 16'hF889, 1'b0);
    sweep(16'hF888, 16'h0220, 16'hF888, 1'b0);

    // Asynchronous reset mid-sweep, then a clean sweep.
    fn_r  = 16'hF888;
    flt_r = 16'd0;
    sb_q.push_back(model(16'hF888, 16'd0, 16'hF888));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_sweep", 32'({a, b, c, d, busy, done, compl_err, pass, err_index, truth_table}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    void'(sb_q.pop_front());
    sweep(16'hF888, 16'd0, 16'hF888, 1'b0);

    sweep(16'hF888, 16'd0, 16'hF888, 1'b1);

    // start held high: back-to-back sweeps with one idle cycle.
    fn_r     = 16'hF888;
    flt_r    = 16'd0;
    expected = 16'hF888;
    sb_q.push_back(model(16'hF888, 16'd0, 16'hF888));
    sb_q.push_back(model(16'hF888, 16'd0, 16'hF888));
    @(posedge clk); #1 start = 1'b1;
    wait_done();
    @(negedge clk);
    check("b2b_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      fn  = 16'($urandom);
      flt = ($urandom_range(0, 2) == 0) ? (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15)) : 16'd0;
      ex  = ($urandom_range(0, 1) == 0) ? fn : fn ^ (16'd1 << $urandom_range(0, 15));
      sweep(fn, flt, ex, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/logicsystem_sweeper.md
Name: logicsystem_sweeper

Overview:
Sequencer that exhaustively exercises the 4-input combinational logicsystem block in hardware. It drives all 16 input combinations in order, waits a programmable settle time, and samples out/out_n for each. It assembles a 16-bit truth table, checks out_n against ~out, and compares the table with an expected value. It sits beside logicsystem as an on-chip self-test and characterisation engine.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a sweep; accepted only in IDLE
expected  input  16  golden truth table; bit i = expected out for vector i
a  output  1  vector bit 0 to logicsystem
b  output  1  vector bit 1
c  output  1  vector bit 2
d  output  1  vector bit 3
out  input  1  logicsystem out
out_n  input  1  logicsystem out_n
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at end of sweep
truth_table  output  16  captured out per vector; bit i = out for {d,c,b,a}=i
compl_err  output  1  out_n == out seen on at least one vector
err_index  output  4  first vector index with compl_err condition
pass  output  1  truth_table == expected and compl_err == 0

Behaviour:
- Reset (async, immediate, including mid-sweep): state IDLE; idx=0 (so a,b,c,d=0); busy=0, done=0, truth_table=0, compl_err=0, err_index=0, pass=0; settle counter=0.
- {d,c,b,a} are driven directly from the registered 4-bit idx. No combinational path from any input to any output.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0. When start=1, set idx=0, clear truth_table, compl_err, err_index, pass and counter, then go to SETTLE. Result registers otherwise hold their last sweep values.
- SETTLE: busy=1. Counter increments each cycle. When counter == SETTLE_CYCLES-1, clear the counter and go to SAMPLE. The vector is stable for exactly SETTLE_CYCLES cycles before the sample cycle.
- SAMPLE: busy=1, one cycle.
  - truth_table[idx] <= out.
  - If out_n == out and compl_err == 0, set compl_err=1 and err_index=idx. Later errors do not overwrite err_index.
  - If idx == 15: go to DONE and set idx=0.
  - Otherwise: idx <= idx+1 and go to SETTLE.
- DONE: busy=0, done=1 for exactly one cycle. pass <= (truth_table == expected) && !compl_err, using the truth_table value that includes the final sample. Then go to IDLE.
- Latency: start accepted at edge k. busy is high for cycles k+1 .. k+16*(SETTLE_CYCLES+1). done is high in the following cycle. With the default SETTLE_CYCLES=2: 48 busy cycles, then done.
- start while busy or in DONE is ignored. start held high continuously gives back-to-back sweeps with exactly one IDLE cycle between them.
- expected is sampled only in DONE and may change at any other time.
- Index wraps 15 -> 0 only through the DONE transition; no extra vectors are applied.

Test Plan:
- Model out=(a&b)|(c&d), out_n=~out, expected=16'hF888, pulse start. Required: busy high 48 cycles, done one cycle, truth_table=16'hF888, compl_err=0, pass=1; a..d step 0..15, each value held 3 cycles.
- Same model with expected=16'hF889. Required: truth_table=16'hF888, pass=0, compl_err=0.
- Same model but force out_n=out for vectors 5 and 9. Required: compl_err=1, err_index=5, pass=0 even with expected=16'hF888.
- Assert rst at cycle 20 of a sweep. Required: outputs zero immediately (before the next edge), state IDLE. A new start then completes normally with pass=1.
- Pulse start repeatedly during busy. Required: no restart, single done at the expected cycle. Then hold start high. Required: second sweep's busy rises two cycles after done.
- Build with SETTLE_CYCLES=1. Required: 32 busy cycles, each vector held 2 cycles, same truth_table result.
